data_mem_arbiter: RTL and testbench

//  Shares the single-port data memory between the processor datapath (CPU port)
//  and a program/data loader or debug port (LDR port). Round-robin arbitration.

---
 rtl/data_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU
// datapath and the loader/debug port. Every access runs ARB -> ISSUE -> RESP.
// Grants, memory strobes and done pulses are registered. Read data and
// cpu_stall are combinational so the PC enable can be gated in the same cycle.
module data_mem_arbiter #(
  parameter int N      = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [N-1:0]      cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [N-1:0]      cpu_rdata,
  output logic              cpu_stall,
  // Loader / debug port
  input  logic              ldr_req,
  input  logic              ldr_wr,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [N-1:0]      ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_done,
  output logic [N-1:0]      ldr_rdata,
  // Data memory side
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [N-1:0]      mem_wdata,
  input  logic [N-1:0]      mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_LDR = 1'b1
  } port_e;

  state_e state_q, state_d;

  // The port granted most recently. It is both the owner of the access in
  // flight and the loser of the next tie, so one register serves both roles.
  port_e last_owner_q;

  logic              cap_wr_q;
  logic [N-1:0]      cpu_hold_q;
  logic [N-1:0]      ldr_hold_q;

  logic              grant;
  port_e             win;
  logic              win_wr;
  logic [ADDR_W-1:0] win_addr;
  logic [N-1:0]      win_wdata;
  logic              resp_read;

  // Next-state and arbitration: requests are sampled in IDLE and in RESP.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    state_d   = state_q;
    grant     = 1'b0;
    win       = PORT_CPU;
    win_wr    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;

    case (state_q)
      IDLE, RESP: begin
        if (cpu_req || ldr_req) begin
          grant   = 1'b1;
          state_d = ISSUE;
          // A lone requester wins; on a tie the port that was not granted last wins.
          if (cpu_req && (!ldr_req || last_owner_q == PORT_LDR)) begin
            win = PORT_CPU;
          end else begin
            win = PORT_LDR;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE:   state_d = RESP;
      default: state_d = IDLE;
    endcase

    if (win == PORT_CPU) begin
      win_wr    = cpu_wr;
      win_addr  = cpu_addr;
      win_wdata = cpu_wdata;
    end else begin
      win_wr    = ldr_wr;
      win_addr  = ldr_addr;
      win_wdata = ldr_wdata;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      state_q <= state_d;
    end
  end

  // Registered outputs, request capture and read-data hold registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the hold registers are plain flops and are cleared like any
      // other state; the memory array lives outside this block.
      last_owner_q <= PORT_LDR;
      cap_wr_q     <= 1'b0;
      cpu_gnt      <= 1'b0;
      ldr_gnt      <= 1'b0;
      cpu_done     <= 1'b0;
      ldr_done     <= 1'b0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_hold_q   <= '0;
      ldr_hold_q   <= '0;
    end else begin
      cpu_gnt  <= grant && (win == PORT_CPU);
      ldr_gnt  <= grant && (win == PORT_LDR);
      // Strobes are raised on the capture edge, so they are high exactly in ISSUE.
      mem_rd   <= grant && !win_wr;
      mem_wr   <= grant &&  win_wr;
      cpu_done <= (state_q == ISSUE) && (last_owner_q == PORT_CPU);
      ldr_done <= (state_q == ISSUE) && (last_owner_q == PORT_LDR);

      // mem_addr/mem_wdata double as the captured request registers.
      if (grant) begin
        last_owner_q <= win;
        cap_wr_q     <= win_wr;
        mem_addr     <= win_addr;
        mem_wdata    <= win_wdata;
      end

      if (resp_read && last_owner_q == PORT_CPU) cpu_hold_q <= mem_rdata;
      if (resp_read && last_owner_q == PORT_LDR) ldr_hold_q <= mem_rdata;
    end
  end

  assign resp_read = (state_q == RESP) && !cap_wr_q;

  // During RESP of a read the owner sees memory data directly; otherwise its hold value.
  assign cpu_rdata = (resp_read && last_owner_q == PORT_CPU) ? mem_rdata : cpu_hold_q;
  assign ldr_rdata = (resp_read && last_owner_q == PORT_LDR) ? mem_rdata : ldr_hold_q;

  assign cpu_stall = cpu_req & ~cpu_done;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios followed by a
// randomized phase, all compared each cycle against a transaction-level model
// (grant order, reference memory contents, per-port read-data holding).
module tb_data_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_wr, ldr_req, ldr_wr;
  logic [AW-1:0] cpu_addr, ldr_addr;
  logic [DW-1:0] cpu_wdata, ldr_wdata;
  logic          cpu_gnt, cpu_done, cpu_stall, ldr_gnt, ldr_done;
  logic [DW-1:0] cpu_rdata, ldr_rdata;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  data_mem_arbiter #(.N(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_wr(ldr_wr), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_done(ldr_done), .ldr_rdata(ldr_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous single-port data memory: read data valid the cycle after mem_rd.
  bit [DW-1:0] mem_array [1024];
  always @(posedge clk) begin
    if (mem_wr) mem_array[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem_array[mem_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
  endtask

  // ---------------- transaction-level reference model ----------------
  // Port 0 = CPU, 1 = LDR. The bus accepts a new grant in any cycle that is
  // not itself a grant cycle; a grant occupies the bus for that cycle and the next.
  bit [DW-1:0] ref_mem [1024];
  bit          m_free;
  bit          m_last;
  bit          g_v, g_port, g_wr;
  bit [AW-1:0] g_addr;
  bit [DW-1:0] g_wd, g_rd;
  bit          r_v, r_port, r_wr;
  bit [DW-1:0] r_rd;
  bit [DW-1:0] hold_c, hold_l;

  int cnt_cgnt, cnt_lgnt, cnt_cdone, cnt_ldone, cnt_strobe;
  int stall_run, stall_max;

  task automatic reset_model();
    m_free = 1'b1;
    m_last = 1'b1;
    g_v    = 1'b0;
    r_v    = 1'b0;
    hold_c = '0;
    hold_l = '0;
  endtask

  // Advance one clock; inputs present now are what the edge samples.
  // Returns at the following negedge after checking every output.
  task automatic cycle();
    bit          cr, lr, cw, lw;
    bit [AW-1:0] ca, la;
    bit [DW-1:0] cd, ld, exp_crd, exp_lrd;
    cr = cpu_req; cw = cpu_wr; ca = cpu_addr; cd = cpu_wdata;
    lr = ldr_req; lw = ldr_wr; la = ldr_addr; ld = ldr_wdata;
    @(posedge clk);
    @(negedge clk);

    r_v = g_v; r_port = g_port; r_wr = g_wr; r_rd = g_rd;
    g_v = 1'b0;
    if (m_free && (cr || lr)) begin
      g_v    = 1'b1;
      g_port = (cr && (!lr || m_last)) ? 1'b0 : 1'b1;
      g_wr   = g_port ? lw : cw;
      g_addr = g_port ? la : ca;
      g_wd   = g_port ? ld : cd;
      m_last = g_port;
      if (g_wr) ref_mem[g_addr] = g_wd;
      else      g_rd = ref_mem[g_addr];
    end
    m_free = !g_v;

    exp_crd = (r_v && !r_wr && !r_port) ? r_rd : hold_c;
    exp_lrd = (r_v && !r_wr &&  r_port) ? r_rd : hold_l;

    check_bit("cpu_gnt",   cpu_gnt,   g_v && !g_port);
    check_bit("ldr_gnt",   ldr_gnt,   g_v &&  g_port);
    check_bit("mem_rd",    mem_rd,    g_v && !g_wr);
    check_bit("mem_wr",    mem_wr,    g_v &&  g_wr);
    check_bit("cpu_done",  cpu_done,  r_v && !r_port);
    check_bit("ldr_done",  ldr_done,  r_v &&  r_port);
    check_bit("cpu_stall", cpu_stall, cr && !(r_v && !r_port));
    check("cpu_rdata", cpu_rdata, exp_crd);
    check("ldr_rdata", ldr_rdata, exp_lrd);
    if (g_v) check("mem_addr", {22'b0, mem_addr}, {22'b0, g_addr});
    if (g_v && g_wr) check("mem_wdata", mem_wdata, g_wd);

    if (r_v && !r_wr) begin
      if (r_port) hold_l = r_rd;
      else        hold_c = r_rd;
    end

    cnt_cgnt   += int'(cpu_gnt);
    cnt_lgnt   += int'(ldr_gnt);
    cnt_cdone  += int'(cpu_done);
    cnt_ldone  += int'(ldr_done);
    cnt_strobe += int'(mem_rd | mem_wr);
    if (cpu_stall) begin
      stall_run++;
      if (stall_run > stall_max) stall_max = stall_run;
    end else begin
      stall_run = 0;
    end
  endtask

  // Assert reset at a negedge, check outputs one delta later and a cycle later, release.
  task automatic do_reset();
    rst = 1'b0;
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    #1;
    check_bit("rst_mem_rd",   mem_rd,   1'b0);
    check_bit("rst_mem_wr",   mem_wr,   1'b0);
    check_bit("rst_cpu_gnt",  cpu_gnt,  1'b0);
    check_bit("rst_ldr_gnt",  ldr_gnt,  1'b0);
    check_bit("rst_cpu_done", cpu_done, 1'b0);
    check("rst_mem_addr",  {22'b0, mem_addr}, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_ldr_rdata", ldr_rdata, 32'h0);
    @(negedge clk);
    check_bit("rst_cpu_done_hold", cpu_done, 1'b0);
    check_bit("rst_mem_rd_hold",   mem_rd,   1'b0);
    reset_model();
    rst = 1'b1;
  endtask

  // CPU access on its own: request, wait (bounded) for the grant, drop the request,
  // and return at the negedge of the RESP cycle.
  task automatic cpu_access(input bit wr, input bit [AW-1:0] addr, input bit [DW-1:0] wd);
    bit seen;
    seen      = 1'b0;
    cpu_req   = 1'b1;
    cpu_wr    = wr;
    cpu_addr  = addr;
    cpu_wdata = wd;
    for (int k = 0; k < 8 && !seen; k++) begin
      cycle();
      if (cpu_gnt) seen = 1'b1;
    end
    check_bit("cpu_gnt_wait", seen, 1'b1);
    cpu_req = 1'b0;
    cycle();
  endtask

  task automatic new_cpu_req();
    cpu_req   = 1'b1;
    cpu_wr    = 1'($urandom_range(1, 0));
    cpu_addr  = AW'($urandom_range(15, 0));
    cpu_wdata = $urandom;
  endtask

  task automatic new_ldr_req();
    ldr_req   = 1'b1;
    ldr_wr    = 1'($urandom_range(1, 0));
    ldr_addr  = AW'($urandom_range(15, 0));
    ldr_wdata = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 1'b0; ldr_wr = 1'b0; ldr_addr = '0; ldr_wdata = '0;
    stall_run = 0; stall_max = 0;
    do_reset();

    // 1: reset during ISSUE of a CPU read abandons it.
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 10'h003;
    cycle();
    check_bit("t1_mem_rd_issue", mem_rd, 1'b1);
    do_reset();
    cycle();

    // 2: CPU write 0xDEADBEEF to 0x005 then read it back.
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 10'h005; cpu_wdata = 32'hDEADBEEF;
    cycle();
    check_bit("t2_wr_gnt_t1",  cpu_gnt, 1'b1);
    check_bit("t2_mem_wr_t1",  mem_wr,  1'b1);
    cpu_req = 1'b0;
    cycle();
    check_bit("t2_done_t2",    cpu_done, 1'b1);
    check_bit("t2_mem_wr_off", mem_wr,   1'b0);
    cpu_access(1'b0, 10'h005, 32'h0);
    check("t2_rdata_resp", cpu_rdata, 32'hDEADBEEF);
    cycle();
    check("t2_rdata_held", cpu_rdata, 32'hDEADBEEF);

    // 3: tie after reset -> CPU first; CPU re-requests in RESP -> LDR wins that tie.
    do_reset();
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 10'h007; cpu_wdata = 32'hA5A5_0007;
    ldr_req = 1'b1; ldr_wr = 1'b1; ldr_addr = 10'h008; ldr_wdata = 32'hB6B6_0008;
    cycle();
    check_bit("t3_cpu_first", cpu_gnt, 1'b1);
    check_bit("t3_ldr_wait",  ldr_gnt, 1'b0);
    cpu_wr = 1'b0; cpu_addr = 10'h008;
    cycle();
    check_bit("t3_cpu_done", cpu_done, 1'b1);
    cycle();
    check_bit("t3_ldr_t3",       ldr_gnt, 1'b1);
    check_bit("t3_cpu_lost_tie", cpu_gnt, 1'b0);
    ldr_wr = 1'b0; ldr_addr = 10'h007;
    cycle();
    cycle();
    check_bit("t3_cpu_t5", cpu_gnt, 1'b1);
    cpu_req = 1'b0;
    cycle();
    check("t3_read_after_write", cpu_rdata, 32'hB6B6_0008);
    check_bit("t3_ldr_pending", ldr_req, 1'b1);
    cycle();
    check_bit("t3_ldr_t7", ldr_gnt, 1'b1);
    ldr_req = 1'b0;
    cycle();
    check("t3_ldr_rdata", ldr_rdata, 32'hA5A5_0007);
    cycle();

    // 4: both ports request continuously for 40 cycles.
    new_cpu_req();
    new_ldr_req();
    cnt_cgnt = 0; cnt_lgnt = 0; stall_run = 0; stall_max = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (cpu_gnt) new_cpu_req();
      if (ldr_gnt) new_ldr_req();
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
    check("t4_cpu_grants", cnt_cgnt, 10);
    check("t4_ldr_grants", cnt_lgnt, 10);
    check_bit("t4_stall_le4", stall_max <= 4, 1'b1);
    cycle();
    cycle();

    // 5: LDR loads 1..16 into addresses 0..15, then CPU reads them back.
    idx = 0;
    ldr_req = 1'b1; ldr_wr = 1'b1; ldr_addr = '0; ldr_wdata = 32'h1;
    cnt_ldone = 0;
    for (int i = 0; i < 32; i++) begin
      cycle();
      if (ldr_gnt) begin
        idx++;
        if (idx < 16) begin
          ldr_addr  = AW'(idx);
          ldr_wdata = 32'(idx + 1);
        end else begin
          ldr_req = 1'b0;
        end
      end
    end
    check("t5_ldr_done_cnt", cnt_ldone, 16);
    for (int a = 0; a < 16; a++) begin
      cpu_access(1'b0, AW'(a), 32'h0);
      check("t5_readback", cpu_rdata, 32'(a + 1));
    end
    cycle();

    // 6: one-cycle CPU pulse while LDR owns the bus.
    ldr_req = 1'b1; ldr_wr = 1'b1; ldr_addr = 10'h014; ldr_wdata = 32'h0000_0066;
    cycle();
    check_bit("t6_ldr_owns", ldr_gnt, 1'b1);
    ldr_req = 1'b0;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 10'h014; cpu_wdata = 32'hBAD0_BAD0;
    cnt_cgnt = 0; cnt_cdone = 0; cnt_strobe = 0;
    cycle();
    cpu_req = 1'b0;
    cycle();
    cycle();
    check("t6_no_cpu_gnt",    cnt_cgnt,   0);
    check("t6_no_cpu_done",   cnt_cdone,  0);
    check("t6_no_cpu_strobe", cnt_strobe, 0);

    // Randomized traffic over 16 shared addresses, checked against the model.
    for (int i = 0; i < 400; i++) begin
      cycle();
      if (cpu_req) begin
        if (cpu_gnt) begin
          if ($urandom_range(1, 0) == 1) new_cpu_req();
          else cpu_req = 1'b0;
        end else if ($urandom_range(15, 0) == 0) begin
          cpu_req = 1'b0;
        end
      end else if ($urandom_range(2, 0) == 0) begin
        new_cpu_req();
      end
      if (ldr_req) begin
        if (ldr_gnt) begin
          if ($urandom_range(1, 0) == 1) new_ldr_req();
          else ldr_req = 1'b0;
        end else if ($urandom_range(15, 0) == 0) begin
          ldr_req = 1'b0;
        end
      end else if ($urandom_range(2, 0) == 0) begin
        new_ldr_req();
      end
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
    cycle();
    cycle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
